// File: rtl/board_pkg.sv
// board_pkg: cell and winner codes, referee FSM states and the winning-line table shared by board_referee
package board_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_X    = 2'b01;
    localparam logic [1:0] WIN_O    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MOVE,
        CHECK,
        DONE
    } state_t;

    // Cell index triples of the 3 rows, 3 columns and 2 diagonals.
    localparam logic [7:0][2:0][3:0] WIN_LINES = {
        4'd0, 4'd1, 4'd2,
        4'd3, 4'd4, 4'd5,
        4'd6, 4'd7, 4'd8,
        4'd0, 4'd3, 4'd6,
        4'd1, 4'd4, 4'd7,
        4'd2, 4'd5, 4'd8,
        4'd0, 4'd4, 4'd8,
        4'd2, 4'd4, 4'd6
    };

    // Cell code written for the player whose turn it is (0 = X, 1 = O).
    function automatic logic [1:0] player_code(input logic turn);
        return turn ? CELL_O : CELL_X;
    endfunction

endpackage

// File: rtl/board_win_detect.sv
// board_win_detect: flags whether any of the 8 winning lines is fully owned by the given player
module board_win_detect
    import board_pkg::*;
(
    input  logic [17:0] matriz,
    input  logic [1:0]  player,
    output logic        line_hit
);

    // a line is hit when all three of its cells hold the player's code
    always_comb begin
        line_hit = 1'b0;
        for (int l = 0; l < 8; l++) begin
            line_hit = line_hit | ((matriz[2*WIN_LINES[l][0] +: 2] == player) &&
                                   (matriz[2*WIN_LINES[l][1] +: 2] == player) &&
                                   (matriz[2*WIN_LINES[l][2] +: 2] == player));
        end
    end

endmodule

// File: rtl/board_referee.sv
// board_referee: tic-tac-toe move referee; define REFEREE_TIMEOUT_EN to make a stalled player forfeit
module board_referee
    import board_pkg::*;
#(
    parameter int FIRST_PLAYER   = 0,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        move_valid,
    input  logic [3:0]  move_coord,
    output logic        move_ready,
    output logic [17:0] matriz,
    output logic        turn,
    output logic        move_reject,
    output logic        game_over,
    output logic [1:0]  winner
);

    localparam logic FIRST = (FIRST_PLAYER != 0);

    state_t      r_state;
    state_t      w_next;
    logic [17:0] r_matriz;
    logic        r_turn;
    logic [3:0]  r_count;
    logic        r_reject;
    logic        r_game_over;
    logic [1:0]  r_winner;
    logic [4:0]  w_shift;
    logic [1:0]  w_cell;
    logic [1:0]  w_mover;
    logic        w_hs;
    logic        w_legal;
    logic        w_hit;
    logic        w_timeout;

    assign w_shift = {move_coord, 1'b0};
    assign w_cell  = 2'(r_matriz >> w_shift);
    assign w_mover = player_code(r_turn);
    assign w_hs    = move_valid && (r_state == WAIT_MOVE);
    assign w_legal = (move_coord <= 4'd8) && (w_cell == CELL_EMPTY);

    board_win_detect u_win (
        .matriz   (r_matriz),
        .player   (w_mover),
        .line_hit (w_hit)
    );

`ifdef REFEREE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_timer;

    assign w_timeout = (r_state == WAIT_MOVE) && !move_valid && (r_timer == TW'(TIMEOUT_CYCLES - 1));

    // counts idle cycles in WAIT_MOVE; any offered move or leaving WAIT_MOVE restarts it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_timer <= '0;
        else
            r_timer <= (start || r_state != WAIT_MOVE || move_valid) ? '0 : r_timer + 1'b1;
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
`endif

    // state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // next state: start always restarts; CHECK resolves the move just written
    always_comb begin
        w_next = start ? WAIT_MOVE
               : (r_state == WAIT_MOVE) ? ((w_hs && w_legal) ? CHECK : (w_timeout ? DONE : WAIT_MOVE))
               : (r_state == CHECK) ? ((w_hit || r_count == 4'd9) ? DONE : WAIT_MOVE)
               : r_state;
    end

    // board, turn, move count, reject pulse and result registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_matriz    <= '0;
            r_turn      <= FIRST;
            r_count     <= '0;
            r_reject    <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= WIN_NONE;
        end else if (start) begin
            r_matriz    <= '0;
            r_turn      <= FIRST;
            r_count     <= '0;
            r_reject    <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= WIN_NONE;
        end else begin
            r_reject <= w_hs && !w_legal;
            if (w_hs && w_legal) begin
                r_matriz <= r_matriz | (18'(w_mover) << w_shift);
                r_count  <= r_count + 4'd1;
            end
            if (w_timeout) begin
                r_game_over <= 1'b1;
                r_winner    <= r_turn ? WIN_X : WIN_O;
            end
            if (r_state == CHECK) begin
                if (w_hit) begin
                    r_game_over <= 1'b1;
                    r_winner    <= w_mover;
                end else if (r_count == 4'd9) begin
                    r_game_over <= 1'b1;
                    r_winner    <= WIN_DRAW;
                end else begin
                    r_turn <= ~r_turn;
                end
            end
        end
    end

    // outputs: only move_ready depends on the state directly
    always_comb begin
        move_ready  = (r_state == WAIT_MOVE);
        matriz      = r_matriz;
        turn        = r_turn;
        move_reject = r_reject;
        game_over   = r_game_over;
        winner      = r_winner;
    end

endmodule

// File: doc/board_referee.md
BOARD_REFEREE -- requirements
Module: board_referee

Interface
REQ-001 Parameter FIRST_PLAYER, default 0; player that moves first after start (0 = X/human, 1 = O/cpu).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000; move timeout in clock cycles; used only when REFEREE_TIMEOUT_EN is defined.
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse; clears board and begins a new game.
REQ-006 move_valid  in  1  move offered on move_coord.
REQ-007 move_coord  in  4  cell index 0..8, row-major (0 = top-left, 8 = bottom-right).
REQ-008 move_ready  out  1  referee accepts a move this cycle.
REQ-009 matriz  out  18  board; cell i at bits [2i+1:2i]; 00 empty, 01 X, 10 O.
REQ-010 turn  out  1  player to move (0 = X, 1 = O).
REQ-011 move_reject  out  1  one-cycle pulse: offered move refused.
REQ-012 game_over  out  1  game finished; held until start or reset.
REQ-013 winner  out  2  00 none, 01 X, 10 O, 11 draw; valid when game_over = 1.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT_MOVE, CHECK and DONE.
REQ-015 IDLE: on start, clear matriz, set turn = FIRST_PLAYER, clear move count, go to WAIT_MOVE.
REQ-016 move_ready SHALL be 1 only in WAIT_MOVE; a handshake is move_valid & move_ready in the same cycle.
REQ-017 On a handshake with move_coord <= 8 and that cell = 00, the current player's code SHALL be written to the cell at that edge, move count incremented, state to CHECK.
REQ-018 On a handshake with move_coord > 8 or an occupied cell, move_reject SHALL pulse for exactly the next cycle; board, turn and state unchanged.
REQ-019 CHECK (one cycle): evaluate the 8 lines (3 rows, 3 columns, 2 diagonals) on the registered board.
REQ-020 If the mover completed a line: winner = mover code, game_over = 1, go to DONE.
REQ-021 If no line and move count = 9: winner = 11, go to DONE.
REQ-022 Otherwise toggle turn and return to WAIT_MOVE.
REQ-023 A win on the 9th move SHALL report the winner, not a draw.
REQ-024 Handshake to updated matriz latency: 1 cycle. Handshake to game_over or turn change: 2 cycles.
REQ-025 DONE: move_ready = 0 and board frozen until start.
REQ-026 start in any state SHALL restart as in REQ-015 and clear game_over and winner; start takes priority over a simultaneous move_valid.
REQ-027 move_valid outside WAIT_MOVE SHALL be ignored with no reject pulse.

Reset
REQ-028 reset_n low SHALL asynchronously force: state IDLE, matriz 0, turn = FIRST_PLAYER, move count 0, move_ready 0, move_reject 0, game_over 0, winner 00, timeout counter 0.
REQ-029 Reset release SHALL take effect on the next rising edge; reset mid-game discards the game.

Configuration
REQ-030 With REFEREE_TIMEOUT_EN defined:
- a counter runs in WAIT_MOVE and clears on every handshake;
- on reaching TIMEOUT_CYCLES - 1 with no handshake, the player to move forfeits: winner = other player, game_over = 1, go to DONE.
REQ-031 Without REFEREE_TIMEOUT_EN, no counter SHALL exist and WAIT_MOVE waits indefinitely.

Structure
REQ-032 Shared package board_pkg SHALL hold:
- cell codes EMPTY/X/O;
- winner codes;
- the FSM state enum;
- the constant table of the 8 winning lines (cell index triples).
REQ-033 Line evaluation SHALL be a combinational sub-module board_win_detect (inputs matriz and player code; output line_hit).

Verification
REQ-034 Scenario 1: start, X plays 0, O plays 3, X plays 1, O plays 4, X plays 2 -> winner 01, game_over 2 cycles after the last handshake, matriz bits [5:0] = 010101.
REQ-035 Scenario 2: cell 4 taken, then move to 4 -> move_reject pulses 1 cycle, turn unchanged; move_coord = 9 -> same result.
REQ-036 Scenario 3: sequence X 0, O 1, X 2, O 4, X 3, O 5, X 7, O 6, X 8 (no line) -> winner 11; a separate sequence whose 9th move completes an X line -> winner 01.
REQ-037 Scenario 4: start asserted in the same cycle as move_valid mid-game -> board cleared, move not written, turn = FIRST_PLAYER.
REQ-038 Scenario 5: reset_n low between clock edges during CHECK -> all outputs at reset values immediately.
REQ-039 Scenario 6 (REFEREE_TIMEOUT_EN, TIMEOUT_CYCLES = 16): O to move, no move_valid for 16 cycles -> winner 01, game_over 1.
